bf16_addsub_arbiter: RTL and testbench
======================================

# bf16_addsub_arbiter

Round-robin arbiter and sequencer sharing one combinational bfloat16 add/sub datapath (`bfloat_add_sub`) among NREQ requesters. The block accepts one operation at a time over a valid/ready handshake and registers the operands that drive the datapath. It captures the datapath result one cycle later and returns it with the requester ID over a back-pressured response channel. It sits between the MAC accumulation/control logic and the shared adder instance.

## Interface
- NREQ, 2, number of requesters; legal values 2..4
- IDW, 2, width of the response ID; must satisfy 2^IDW >= NREQ

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_a  in  16*NREQ  operand A per requester, slice i = [16*i+15:16*i]
- req_b  in  16*NREQ  operand B per requester, same slicing
- req_op  in  NREQ  per-requester op: 0 = a+b, 1 = a-b
- dp_a  out  16  registered operand A to datapath `a`
- dp_b  out  16  registered operand B to datapath `b`
- dp_cntl  out  1  registered op to datapath `cntl`
- dp_c  in  16  datapath result `c`; combinational from dp_a/dp_b/dp_cntl
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_c  out  16  registered result
- rsp_id  out  IDW  index of the requester that issued the operation
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid bit is set, grant the first set bit found searching from (last+1) mod NREQ upward with wrap.
  - Assert req_ready for the granted bit only, in the same cycle (combinational from req_valid and the pointer).
  - On the edge: latch the granted operands and op into dp_a/dp_b/dp_cntl, latch the ID, set last = granted index, go to EXEC.
- EXEC: datapath settles; on the edge, latch dp_c into rsp_c and go to RESP.
- RESP: rsp_valid = 1. rsp_c and rsp_id stay stable until rsp_valid && rsp_ready; on that edge go to IDLE.
- Requesters hold req_valid and operands stable until req_ready. Dropping req_valid early is legal; the requester is simply not granted.
- Requests arriving in EXEC/RESP wait; req_ready stays 0 outside IDLE.
- dp_* hold their last values outside the IDLE→EXEC edge, so the datapath input never glitches during EXEC/RESP.
- The arbiter performs no arithmetic; it passes dp_c through bit-exact, including NaN (0xFFFF), ±inf and signed-zero encodings.

## Timing
- Reset (rst_n = 0 at edge):
  - state = IDLE; last = NREQ-1, so requester 0 wins first.
  - dp_a = dp_b = 0, dp_cntl = 0, rsp_c = 0, rsp_id = 0.
  - rsp_valid = 0, busy = 0, req_ready = 0 while rst_n is low.
- Latency: accept edge (cycle 0) → rsp_valid high from cycle 2; minimum issue interval 3 cycles when rsp_ready is tied high.
- If rsp_ready is high in the first RESP cycle, the next request can be accepted in the cycle after the response handshake.
- Reset mid-operation: the in-flight op is discarded, no response is produced, and the FSM returns to IDLE.
- Single requester always valid: it is granted every 3 cycles. All requesters valid: grants rotate 0,1,…,NREQ-1,0.

## Configuration
- BF16_ARB_FLAGS_EN defined:
  - Adds output rsp_flags [3:0] = {nan, inf, zero, neg}, decoded from dp_c and registered alongside rsp_c. Reset value 0.
  - nan = exp all-ones and mantissa nonzero; inf = exp all-ones and mantissa zero; zero = exp zero; neg = bit 15.
- Not defined: port and logic absent; all other behaviour identical.

## Test plan
- Single op: req 0 valid, a=0x3F80, b=0x4000, op=0 → req_ready[0] one cycle; rsp_valid 2 cycles later with rsp_c=0x4040, rsp_id=0.
- Subtraction on req 1: a=0x4040, b=0x3F80, op=1 → rsp_c=0x4000, rsp_id=1; with flags enabled, rsp_flags=0000.
- Fairness: all NREQ=2 requesters valid continuously, rsp_ready=1 → rsp_id sequence 0,1,0,1; each response 3 cycles apart.
- Back-pressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_c/rsp_id stable, req_ready stays 0, busy=1; release → handshake, then IDLE.
- Special values: a=0x7F80, b=0x7F80, op=1 → rsp_c=0xFFFF; with flags enabled, rsp_flags=1001.
- Reset in EXEC: assert rst_n=0 for one cycle → no rsp_valid; all outputs read reset values; next grant goes to requester 0.

Source files
------------

// File: rtl/bf16_addsub_arbiter_if.sv
// ---------------------------------------------------------------------------
// bf16_addsub_arbiter_if
// Request/response bundle between NREQ requesters and the shared bf16
// add/sub arbiter.
//   req_valid/req_ready : per-requester handshake (one ready bit at a time)
//   req_a/req_b         : operand pairs, slice i = [16*i+15:16*i]
//   req_op              : per-requester op, 0 = a+b, 1 = a-b
//   rsp_valid/rsp_ready : back-pressured response handshake
//   rsp_c/rsp_id        : result and issuing requester index
//   rsp_flags           : {nan, inf, zero, neg}, only with BF16_ARB_FLAGS_EN
// Optional feature macro: BF16_ARB_FLAGS_EN
// ---------------------------------------------------------------------------
interface bf16_addsub_arbiter_if #(
   parameter int NREQ = 2,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [16*NREQ-1:0] req_a;
   logic [16*NREQ-1:0] req_b;
   logic [NREQ-1:0]    req_op;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [15:0]        rsp_c;
   logic [IDW-1:0]     rsp_id;
`ifdef BF16_ARB_FLAGS_EN
   logic [3:0]         rsp_flags;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_c, rsp_id, rsp_flags
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_c, rsp_id, rsp_flags
   );
`else
   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_c, rsp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_c, rsp_id
   );
`endif
endinterface

// File: rtl/bf16_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// bf16_addsub_arbiter
// Round-robin arbiter/sequencer sharing one combinational bf16 add/sub
// datapath among NREQ requesters. One operation is in flight at a time:
// IDLE (grant + latch operands) -> EXEC (datapath settles, capture result)
// -> RESP (hold result until rsp_ready).
// Ports:
//   clk     : clock, all state on rising edge
//   rst_n   : synchronous active-low reset
//   bus     : request/response bundle (slave side)
//   dp_a    : registered operand A to the shared datapath
//   dp_b    : registered operand B to the shared datapath
//   dp_cntl : registered op to the shared datapath (0 add, 1 sub)
//   dp_c    : combinational datapath result
//   busy    : high whenever not IDLE
// Optional feature macro: BF16_ARB_FLAGS_EN adds bus.rsp_flags =
// {nan, inf, zero, neg} decoded from dp_c and registered with rsp_c.
// ---------------------------------------------------------------------------
module bf16_addsub_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   bf16_addsub_arbiter_if.slave         bus,
   output logic [15:0]                  dp_a,
   output logic [15:0]                  dp_b,
   output logic                         dp_cntl,
   input  logic [15:0]                  dp_c,
   output logic                         busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Pointer resets to the highest index so requester 0 wins first.
   localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

   logic [1:0]      state_r;
   logic [IDW-1:0]  last_r;
   logic [IDW-1:0]  id_r;
   logic [15:0]     dp_a_r;
   logic [15:0]     dp_b_r;
   logic            dp_cntl_r;
   logic [15:0]     rsp_c_r;
   logic            rsp_valid_r;
   logic            busy_r;

   logic            hi_found_s;
   logic            lo_found_s;
   logic [IDW-1:0]  hi_idx_s;
   logic [IDW-1:0]  lo_idx_s;
   logic            grant_found_s;
   logic [IDW-1:0]  grant_idx_s;
   logic [15:0]     grant_a_s;
   logic [15:0]     grant_b_s;
   logic            grant_op_s;
   logic [NREQ-1:0] req_ready_s;

`ifdef BF16_ARB_FLAGS_EN
   logic [3:0]      flags_r;

   // {nan, inf, zero, neg} classification of a bf16 encoding.
   // zero means exponent zero, so subnormals also report zero.
   function automatic logic [3:0] decode_flags(input logic [15:0] v);
      logic exp_ones;
      logic exp_zero;
      logic man_zero;
      exp_ones = (v[14:7] == 8'hFF);
      exp_zero = (v[14:7] == 8'h00);
      man_zero = (v[6:0] == 7'h00);
      return {exp_ones & ~man_zero, exp_ones & man_zero, exp_zero, v[15]};
   endfunction
`endif

   // Round-robin search: the lowest valid index above the pointer wins;
   // otherwise the lowest valid index at or below it (the wrapped part).
   always_comb begin
      hi_found_s = 1'b0;
      lo_found_s = 1'b0;
      hi_idx_s   = {IDW{1'b0}};
      lo_idx_s   = {IDW{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         if (bus.req_valid[i] && (IDW'(i) > last_r) && !hi_found_s) begin
            hi_found_s = 1'b1;
            hi_idx_s   = IDW'(i);
         end else if (bus.req_valid[i] && (IDW'(i) <= last_r) && !lo_found_s) begin
            lo_found_s = 1'b1;
            lo_idx_s   = IDW'(i);
         end else begin
            hi_idx_s   = hi_idx_s;
         end
      end
      grant_found_s = hi_found_s | lo_found_s;
      grant_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
   end

   // Operand mux for the granted requester and the one-hot ready vector.
   always_comb begin
      grant_a_s   = 16'h0000;
      grant_b_s   = 16'h0000;
      grant_op_s  = 1'b0;
      req_ready_s = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx_s == IDW'(i)) begin
            grant_a_s      = bus.req_a[16*i +: 16];
            grant_b_s      = bus.req_b[16*i +: 16];
            grant_op_s     = bus.req_op[i];
            req_ready_s[i] = rst_n && (state_r == ST_IDLE) && grant_found_s;
         end else begin
            req_ready_s[i] = 1'b0;
         end
      end
   end

   // Sequencer: operands change only on the accept edge so the datapath
   // inputs stay quiet through EXEC and RESP.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         last_r      <= LAST_RST;
         id_r        <= {IDW{1'b0}};
         dp_a_r      <= 16'h0000;
         dp_b_r      <= 16'h0000;
         dp_cntl_r   <= 1'b0;
         rsp_c_r     <= 16'h0000;
         rsp_valid_r <= 1'b0;
         busy_r      <= 1'b0;
`ifdef BF16_ARB_FLAGS_EN
         flags_r     <= 4'b0000;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_found_s) begin
                  dp_a_r    <= grant_a_s;
                  dp_b_r    <= grant_b_s;
                  dp_cntl_r <= grant_op_s;
                  id_r      <= grant_idx_s;
                  last_r    <= grant_idx_s;
                  busy_r    <= 1'b1;
                  state_r   <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_c_r     <= dp_c;
`ifdef BF16_ARB_FLAGS_EN
               flags_r     <= decode_flags(dp_c);
`endif
               rsp_valid_r <= 1'b1;
               state_r     <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_c     = rsp_c_r;
   assign bus.rsp_id    = id_r;
`ifdef BF16_ARB_FLAGS_EN
   assign bus.rsp_flags = flags_r;
`endif
   assign dp_a          = dp_a_r;
   assign dp_b          = dp_b_r;
   assign dp_cntl       = dp_cntl_r;
   assign busy          = busy_r;

endmodule

// File: tb/tb_bf16_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bf16_addsub_arbiter
// Directed scenarios with literal expectations, then randomized traffic.
// A transaction-level model predicts every output each cycle. The shared
// adder is stood in by dp_fn, which is exact for the directed vectors.
// ---------------------------------------------------------------------------
module tb_bf16_addsub_arbiter;
   localparam int NREQ = 2;
   localparam int IDW  = 2;

   logic              clk;
   logic              rst_n;
   logic [15:0]       dp_a;
   logic [15:0]       dp_b;
   logic              dp_cntl;
   logic [15:0]       dp_c;
   logic              busy;
   logic [NREQ-1:0]   vld;
   logic [NREQ-1:0]   rop;
   logic [15:0]       ra [NREQ];
   logic [15:0]       rb [NREQ];
   int                checks;
   int                errors;

   // model state
   int                m_phase;   // 0 free, 1 computing, 2 responding
   int                m_last;
   int                m_id;
   logic [15:0]       m_dp_a;
   logic [15:0]       m_dp_b;
   logic              m_cntl;
   logic [15:0]       m_c;
   logic [3:0]        m_flags;

   bf16_addsub_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   bf16_addsub_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .dp_a    (dp_a),
      .dp_b    (dp_b),
      .dp_cntl (dp_cntl),
      .dp_c    (dp_c),
      .busy    (busy)
   );

   function automatic logic [15:0] dp_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic op);
      if (a == 16'h3F80 && b == 16'h4000 && !op) return 16'h4040;   // 1 + 2 = 3
      if (a == 16'h4040 && b == 16'h3F80 && op)  return 16'h4000;   // 3 - 1 = 2
      if (a == 16'h7F80 && b == 16'h7F80 && op)  return 16'hFFFF;   // inf - inf = NaN
      return (a ^ {b[7:0], b[15:8]}) + {15'd0, op} + 16'h0101;
   endfunction

   function automatic logic [3:0] flag_fn(input logic [15:0] c);
      logic [7:0] e;
      logic [6:0] m;
      e = c[14:7];
      m = c[6:0];
      return {(e == 8'd255) && (m != 7'd0), (e == 8'd255) && (m == 7'd0), e == 8'd0, c[15]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always_comb begin
      bus.req_valid = vld;
      bus.req_op    = rop;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[16*i +: 16] = ra[i];
         bus.req_b[16*i +: 16] = rb[i];
      end
   end

   always_comb dp_c = dp_fn(dp_a, dp_b, dp_cntl);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare process: at each falling edge check outputs against the model,
   // then advance the model by what the coming rising edge must do.
   initial begin
      int g;
      int idx;
      logic [NREQ-1:0] exp_ready;
      m_phase = 0; m_last = NREQ - 1; m_id = 0;
      m_dp_a = 16'h0000; m_dp_b = 16'h0000; m_cntl = 1'b0;
      m_c = 16'h0000; m_flags = 4'b0000;
      forever begin
         @(negedge clk);
         g = -1;
         exp_ready = '0;
         if (rst_n === 1'b1 && m_phase == 0) begin
            for (int k = 1; k <= NREQ; k++) begin
               idx = (m_last + k) % NREQ;
               if (g < 0 && vld[idx]) g = idx;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
         end
         chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
         chk("busy",      32'(busy),          32'(m_phase != 0));
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_phase == 2));
         chk("dp_a",      32'(dp_a),          32'(m_dp_a));
         chk("dp_b",      32'(dp_b),          32'(m_dp_b));
         chk("dp_cntl",   32'(dp_cntl),       32'(m_cntl));
         chk("rsp_c",     32'(bus.rsp_c),     32'(m_c));
         chk("rsp_id",    32'(bus.rsp_id),    32'(m_id));
`ifdef BF16_ARB_FLAGS_EN
         chk("rsp_flags", 32'(bus.rsp_flags), 32'(m_flags));
`endif
         if (rst_n !== 1'b1) begin
            m_phase = 0; m_last = NREQ - 1; m_id = 0;
            m_dp_a = 16'h0000; m_dp_b = 16'h0000; m_cntl = 1'b0;
            m_c = 16'h0000; m_flags = 4'b0000;
         end else if (m_phase == 0) begin
            if (g >= 0) begin
               m_dp_a = ra[g]; m_dp_b = rb[g]; m_cntl = rop[g];
               m_id = g; m_last = g; m_phase = 1;
            end
         end else if (m_phase == 1) begin
            m_c = dp_fn(m_dp_a, m_dp_b, m_cntl);
            m_flags = flag_fn(m_c);
            m_phase = 2;
         end else if (bus.rsp_ready) begin
            m_phase = 0;
         end
      end
   end

   // Stimulus with literal expectations
   initial begin
      int rt[$];
      int rid[$];
      logic [15:0] rc[$];
      logic [31:0] r;
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      vld = '0;
      rop = '0;
      for (int i = 0; i < NREQ; i++) begin
         ra[i] = 16'h0000;
         rb[i] = 16'h0000;
      end
      bus.rsp_ready = 1'b1;

      // reset state, ready held low while in reset even with requests
      tick(2);
      vld = 2'b11;
      #1;
      chk("rst_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_c",     32'(bus.rsp_c), 32'h0);
      vld = 2'b00;
      rst_n = 1'b1;
      tick(1);

      // single add on requester 0
      ra[0] = 16'h3F80; rb[0] = 16'h4000; rop[0] = 1'b0; vld = 2'b01;
      #1;
      chk("add_ready", 32'(bus.req_ready), 32'h1);
      tick(1);
      vld = 2'b00;
      chk("add_exec_valid", 32'(bus.rsp_valid), 32'h0);
      chk("add_exec_busy",  32'(busy), 32'h1);
      tick(1);
      chk("add_valid", 32'(bus.rsp_valid), 32'h1);
      chk("add_c",     32'(bus.rsp_c), 32'h4040);
      chk("add_id",    32'(bus.rsp_id), 32'h0);
      tick(1);
      chk("add_idle_busy", 32'(busy), 32'h0);

      // subtract on requester 1
      ra[1] = 16'h4040; rb[1] = 16'h3F80; rop[1] = 1'b1; vld = 2'b10;
      #1;
      chk("sub_ready", 32'(bus.req_ready), 32'h2);
      tick(1);
      vld = 2'b00;
      tick(1);
      chk("sub_c",  32'(bus.rsp_c), 32'h4000);
      chk("sub_id", 32'(bus.rsp_id), 32'h1);
`ifdef BF16_ARB_FLAGS_EN
      chk("sub_flags", 32'(bus.rsp_flags), 32'h0);
`endif
      tick(1);

      // inf - inf passes through as NaN
      ra[0] = 16'h7F80; rb[0] = 16'h7F80; rop[0] = 1'b1; vld = 2'b01;
      tick(1);
      vld = 2'b00;
      tick(1);
      chk("nan_c",  32'(bus.rsp_c), 32'hFFFF);
      chk("nan_id", 32'(bus.rsp_id), 32'h0);
`ifdef BF16_ARB_FLAGS_EN
      chk("nan_flags", 32'(bus.rsp_flags), 32'h9);
`endif
      tick(1);

      // back-pressure: response held 5 cycles while both requesters wait
      ra[0] = 16'h3F80; rb[0] = 16'h4000; rop[0] = 1'b0; vld = 2'b01;
      bus.rsp_ready = 1'b0;
      tick(1);
      vld = 2'b11;
      tick(1);
      for (int n = 0; n < 5; n++) begin
         chk("bp_valid", 32'(bus.rsp_valid), 32'h1);
         chk("bp_c",     32'(bus.rsp_c), 32'h4040);
         chk("bp_id",    32'(bus.rsp_id), 32'h0);
         chk("bp_ready", 32'(bus.req_ready), 32'h0);
         chk("bp_busy",  32'(busy), 32'h1);
         tick(1);
      end
      bus.rsp_ready = 1'b1;
      tick(1);
      chk("bp_idle_busy",  32'(busy), 32'h0);
      chk("bp_idle_valid", 32'(bus.rsp_valid), 32'h0);
      chk("bp_next_grant", 32'(bus.req_ready), 32'h2);
      vld = 2'b00;
      tick(1);

      // reset while in EXEC discards the operation
      vld = 2'b10;
      tick(1);
      vld = 2'b00;
      chk("rx_exec_busy", 32'(busy), 32'h1);
      chk("rx_exec_dpa",  32'(dp_a), 32'h4040);
      rst_n = 1'b0;
      tick(1);
      chk("rx_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rx_busy",  32'(busy), 32'h0);
      chk("rx_dpa",   32'(dp_a), 32'h0);
      chk("rx_dpb",   32'(dp_b), 32'h0);
      chk("rx_cntl",  32'(dp_cntl), 32'h0);
      chk("rx_c",     32'(bus.rsp_c), 32'h0);
      chk("rx_id",    32'(bus.rsp_id), 32'h0);
      vld = 2'b11;
      #1;
      chk("rx_ready_low", 32'(bus.req_ready), 32'h0);
      rst_n = 1'b1;
      #1;
      chk("rx_first_grant", 32'(bus.req_ready), 32'h1);

      // fairness: both valid, rsp_ready high -> ids 0,1,0,1, 3 cycles apart
      for (int t = 0; t < 12; t++) begin
         if (bus.rsp_valid === 1'b1) begin
            rt.push_back(t);
            rid.push_back(int'(bus.rsp_id));
            rc.push_back(bus.rsp_c);
         end
         tick(1);
      end
      vld = 2'b00;
      chk("fair_count", 32'(rt.size()), 32'd4);
      for (int j = 0; j < rt.size() && j < 4; j++) begin
         chk("fair_id", 32'(rid[j]), 32'(j % 2));
         chk("fair_c",  32'(rc[j]), (j % 2 == 0) ? 32'h4040 : 32'h4000);
         if (j > 0) chk("fair_gap", 32'(rt[j] - rt[j-1]), 32'd3);
      end
      tick(2);

      // randomized traffic
      for (int cyc = 0; cyc < 400; cyc++) begin
         bus.rsp_ready = ($urandom_range(3, 0) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (vld[i]) begin
               if ($urandom_range(7, 0) == 0) vld[i] = 1'b0;
            end else if ($urandom_range(1, 0) == 1) begin
               r = $urandom;
               case (r[2:0])
                  3'd0: ra[i] = 16'h7F80;
                  3'd1: ra[i] = 16'h8000;
                  3'd2: ra[i] = 16'h7FC1;
                  default: ra[i] = r[31:16];
               endcase
               r = $urandom;
               rb[i] = r[15:0];
               rop[i] = r[16];
               vld[i] = 1'b1;
            end
         end
         tick(1);
      end
      vld = '0;
      bus.rsp_ready = 1'b1;
      tick(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
